// File: rtl/match_controller.sv
// Pong match sequencer: serve countdown, miss detection, scoring, pause and
// match-over handling. Every output is registered.
module match_controller #(
   parameter int SCREEN_WIDTH  = 640,
   parameter int SCREEN_HEIGHT = 480,
   parameter int PAD_WIDTH     = 8,
   parameter int PAD_DISTANCE  = 16,
   parameter int PAD_HEIGHT    = 64,
   parameter int WIN_SCORE     = 7,
   parameter int SERVE_TICKS   = 60,
   parameter int POINT_TICKS   = 30
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       start,
   input  logic       pause,
   input  logic [9:0] ball_x,
   input  logic [8:0] ball_y,
   input  logic [9:0] pad_left,
   input  logic [9:0] pad_right,
   output logic       run,
   output logic       serve,
   output logic       serve_dir,
   output logic [3:0] score_left,
   output logic [3:0] score_right,
   output logic [1:0] winner,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_SERVE  = 3'd1;
   localparam logic [2:0] S_PLAY   = 3'd2;
   localparam logic [2:0] S_POINT  = 3'd3;
   localparam logic [2:0] S_PAUSED = 3'd4;
   localparam logic [2:0] S_OVER   = 3'd5;

   // A paddle taller than the playfield is treated as spanning the whole field.
   localparam int SPAN_INT = ((PAD_HEIGHT < SCREEN_HEIGHT) ? PAD_HEIGHT : SCREEN_HEIGHT) - 1;

   localparam logic [10:0] LEFT_LIMIT  = 11'(PAD_DISTANCE + PAD_WIDTH);
   localparam logic [10:0] RIGHT_LIMIT = 11'(SCREEN_WIDTH - PAD_WIDTH - PAD_DISTANCE);
   localparam logic [10:0] PAD_SPAN    = 11'(SPAN_INT);
   localparam logic [7:0]  SERVE_LOAD  = 8'(SERVE_TICKS);
   localparam logic [7:0]  POINT_LOAD  = 8'(POINT_TICKS);
   localparam logic [3:0]  WIN         = 4'(WIN_SCORE);

   logic [2:0] state_reg, state_next;
   logic [7:0] count_reg, count_next;
   logic [3:0] score_left_reg, score_left_next;
   logic [3:0] score_right_reg, score_right_next;
   logic [1:0] winner_reg, winner_next;
   logic       serve_dir_reg, serve_dir_next;
   logic       run_reg, run_next;
   logic       serve_reg, serve_next;
   logic       start_d_reg, pause_d_reg;

   logic        start_rise, pause_rise;
   logic [10:0] bx, by, left_top, left_bot, right_top, right_bot;
   logic        left_miss, right_miss;
   logic [3:0]  left_inc, right_inc;

   assign start_rise = start & ~start_d_reg;
   assign pause_rise = pause & ~pause_d_reg;

   assign bx        = {1'b0, ball_x};
   assign by        = {2'b0, ball_y};
   assign left_top  = {1'b0, pad_left};
   assign left_bot  = left_top + PAD_SPAN;
   assign right_top = {1'b0, pad_right};
   assign right_bot = right_top + PAD_SPAN;

   assign left_miss  = (bx <= LEFT_LIMIT)  && ((by < left_top)  || (by > left_bot));
   assign right_miss = (bx >= RIGHT_LIMIT) && ((by < right_top) || (by > right_bot));

   assign left_inc  = (score_left_reg  == 4'd15) ? 4'd15 : score_left_reg  + 4'd1;
   assign right_inc = (score_right_reg == 4'd15) ? 4'd15 : score_right_reg + 4'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg       <= S_IDLE;
         count_reg       <= 8'd0;
         score_left_reg  <= 4'd0;
         score_right_reg <= 4'd0;
         winner_reg      <= 2'b00;
         serve_dir_reg   <= 1'b1;
         run_reg         <= 1'b0;
         serve_reg       <= 1'b0;
         start_d_reg     <= 1'b1;
         pause_d_reg     <= 1'b1;
      end else begin
         state_reg       <= state_next;
         count_reg       <= count_next;
         score_left_reg  <= score_left_next;
         score_right_reg <= score_right_next;
         winner_reg      <= winner_next;
         serve_dir_reg   <= serve_dir_next;
         run_reg         <= run_next;
         serve_reg       <= serve_next;
         start_d_reg     <= start;
         pause_d_reg     <= pause;
      end
   end

   always_comb begin
      state_next       = state_reg;
      count_next       = count_reg;
      score_left_next  = score_left_reg;
      score_right_next = score_right_reg;
      winner_next      = winner_reg;
      serve_dir_next   = serve_dir_reg;
      case (state_reg)
         S_IDLE, S_OVER: begin
            if (start_rise) begin
               score_left_next  = 4'd0;
               score_right_next = 4'd0;
               winner_next      = 2'b00;
               serve_dir_next   = 1'b1;
               count_next       = SERVE_LOAD;
               state_next       = S_SERVE;
            end
         end
         S_SERVE: begin
            if (tick) begin
               if (count_reg <= 8'd1) begin
                  count_next = 8'd0;
                  state_next = S_PLAY;
               end else begin
                  count_next = count_reg - 8'd1;
               end
            end
         end
         S_PLAY: begin
            // A pause edge pre-empts any miss evaluated on the same cycle.
            if (pause_rise) begin
               state_next = S_PAUSED;
            end else if (tick && left_miss) begin
               score_right_next = right_inc;
               serve_dir_next   = 1'b0;
               if (right_inc == WIN) begin
                  winner_next = 2'b10;
                  state_next  = S_OVER;
               end else begin
                  count_next = POINT_LOAD;
                  state_next = S_POINT;
               end
            end else if (tick && right_miss) begin
               score_left_next = left_inc;
               serve_dir_next  = 1'b1;
               if (left_inc == WIN) begin
                  winner_next = 2'b01;
                  state_next  = S_OVER;
               end else begin
                  count_next = POINT_LOAD;
                  state_next = S_POINT;
               end
            end
         end
         S_POINT: begin
            if (tick) begin
               if (count_reg <= 8'd1) begin
                  count_next = SERVE_LOAD;
                  state_next = S_SERVE;
               end else begin
                  count_next = count_reg - 8'd1;
               end
            end
         end
         S_PAUSED: begin
            if (pause_rise) state_next = S_PLAY;
         end
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      run_next   = (state_next == S_PLAY);
      serve_next = (state_reg == S_SERVE) && (state_next == S_PLAY);
   end

   assign run         = run_reg;
   assign serve       = serve_reg;
   assign serve_dir   = serve_dir_reg;
   assign score_left  = score_left_reg;
   assign score_right = score_right_reg;
   assign winner      = winner_reg;
   assign state       = state_reg;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller: expected snapshots are queued before
// each step and popped/compared once the DUT has registered the step.
module tb_match_controller;

   logic       clk = 1'b0;
   logic       rst_n, tick, start, pause;
   logic [9:0] ball_x, pad_left, pad_right;
   logic [8:0] ball_y;
   logic       run, serve, serve_dir;
   logic [3:0] score_left, score_right;
   logic [1:0] winner;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;
   int serve_cnt = 0;

   logic [14:0] exp_q[$];
   string       tag_q[$];

   match_controller dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .pause(pause),
      .ball_x(ball_x), .ball_y(ball_y), .pad_left(pad_left), .pad_right(pad_right),
      .run(run), .serve(serve), .serve_dir(serve_dir),
      .score_left(score_left), .score_right(score_right),
      .winner(winner), .state(state)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (serve === 1'b1) serve_cnt++;

   initial begin
      #1ms;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
      tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) cyc(1'b1);
   endtask

   task automatic push(input string tag, input logic [2:0] st, input logic r, input logic sd,
                       input logic [3:0] sl, input logic [3:0] sr, input logic [1:0] w);
      exp_q.push_back({st, r, sd, sl, sr, w});
      tag_q.push_back(tag);
   endtask

   task automatic pop_check();
      logic [14:0] obs, expv;
      string t;
      obs  = {state, run, serve_dir, score_left, score_right, winner};
      expv = exp_q.pop_front();
      t    = tag_q.pop_front();
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed st=%0d run=%b dir=%b L=%0d R=%0d w=%b expected st=%0d run=%b dir=%b L=%0d R=%0d w=%b",
                t, obs[14:12], obs[11], obs[10], obs[9:6], obs[5:2], obs[1:0],
                expv[14:12], expv[11], expv[10], expv[9:6], expv[5:2], expv[1:0]);
      end
      $display("check %s state=%0d run=%b dir=%b L=%0d R=%0d w=%b", t, state, run, serve_dir,
               score_left, score_right, winner);
   endtask

   task automatic step(input string tag, input logic t, input logic [2:0] st, input logic r,
                       input logic sd, input logic [3:0] sl, input logic [3:0] sr, input logic [1:0] w);
      push(tag, st, r, sd, sl, sr, w);
      cyc(t);
      pop_check();
   endtask

   task automatic check_now(input string tag, input logic [2:0] st, input logic r, input logic sd,
                            input logic [3:0] sl, input logic [3:0] sr, input logic [1:0] w);
      push(tag, st, r, sd, sl, sr, w);
      pop_check();
   endtask

   task automatic chk_val(input string tag, input int obs, input int expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
      $display("check %s value=%0d", tag, obs);
   endtask

   task automatic mid_ball();
      ball_x = 10'd320;
      ball_y = 9'd200;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b1; pause = 1'b0; tick = 1'b0;
      pad_left = 10'd100; pad_right = 10'd300;
      mid_ball();
      repeat (3) cyc(1'b0);
      rst_n = 1'b1;

      // start held through reset must not fire
      step("reset_idle", 0, 3'd0, 0, 1, 4'd0, 4'd0, 2'b00);
      step("held_start", 0, 3'd0, 0, 1, 4'd0, 4'd0, 2'b00);
      start = 1'b0;
      step("start_low", 0, 3'd0, 0, 1, 4'd0, 4'd0, 2'b00);
      start = 1'b1;
      step("start_rise", 0, 3'd1, 0, 1, 4'd0, 4'd0, 2'b00);
      start = 1'b0;

      ticks(59);
      check_now("serve_59", 3'd1, 0, 1, 4'd0, 4'd0, 2'b00);
      step("serve_60", 1, 3'd2, 1, 1, 4'd0, 4'd0, 2'b00);
      chk_val("serve_pulse", int'(serve), 1);
      step("play_hold", 0, 3'd2, 1, 1, 4'd0, 4'd0, 2'b00);
      chk_val("serve_drop", int'(serve), 0);
      chk_val("serve_count1", serve_cnt, 1);

      // left miss, point freeze, re-serve
      ball_x = 10'd24; ball_y = 9'd300;
      step("left_miss", 1, 3'd3, 0, 0, 4'd0, 4'd1, 2'b00);
      mid_ball();
      ticks(29);
      check_now("point_29", 3'd3, 0, 0, 4'd0, 4'd1, 2'b00);
      step("point_30", 1, 3'd1, 0, 0, 4'd0, 4'd1, 2'b00);
      ticks(60);
      check_now("replay1", 3'd2, 1, 0, 4'd0, 4'd1, 2'b00);

      // paddle window boundary: 100..163 inclusive
      ball_x = 10'd24; ball_y = 9'd163;
      step("pad_edge_hit", 1, 3'd2, 1, 0, 4'd0, 4'd1, 2'b00);
      ball_y = 9'd164;
      step("pad_edge_miss", 1, 3'd3, 0, 0, 4'd0, 4'd2, 2'b00);
      mid_ball();
      ticks(90);
      check_now("replay2", 3'd2, 1, 0, 4'd0, 4'd2, 2'b00);

      // right column boundary at 616
      ball_x = 10'd615; ball_y = 9'd10;
      step("right_edge_safe", 1, 3'd2, 1, 0, 4'd0, 4'd2, 2'b00);
      ball_x = 10'd616;
      step("right_miss", 1, 3'd3, 0, 1, 4'd1, 4'd2, 2'b00);
      mid_ball();
      ticks(90);
      check_now("replay3", 3'd2, 1, 1, 4'd1, 4'd2, 2'b00);
      cyc(1'b0);
      chk_val("serve_count4", serve_cnt, 4);

      // pause freezes the field, misses ignored
      pause = 1'b1;
      step("pause_enter", 0, 3'd4, 0, 1, 4'd1, 4'd2, 2'b00);
      ball_x = 10'd24; ball_y = 9'd300;
      ticks(10);
      check_now("pause_frozen", 3'd4, 0, 1, 4'd1, 4'd2, 2'b00);
      pause = 1'b0;
      cyc(1'b0);
      pause = 1'b1;
      step("pause_exit", 0, 3'd2, 1, 1, 4'd1, 4'd2, 2'b00);
      chk_val("no_serve_on_resume", int'(serve), 0);
      pause = 1'b0;
      step("miss_without_tick", 0, 3'd2, 1, 1, 4'd1, 4'd2, 2'b00);
      pause = 1'b1;
      step("pause_vs_miss", 1, 3'd4, 0, 1, 4'd1, 4'd2, 2'b00);
      pause = 1'b0;
      cyc(1'b0);
      pause = 1'b1;
      step("resume2", 0, 3'd2, 1, 1, 4'd1, 4'd2, 2'b00);
      pause = 1'b0;
      mid_ball();

      // six more right misses take the left player to 7
      for (int i = 0; i < 6; i++) begin
         ball_x = 10'd616; ball_y = 9'd10;
         cyc(1'b1);
         mid_ball();
         if (i < 5) ticks(90);
      end
      check_now("match_over", 3'd5, 0, 1, 4'd7, 4'd2, 2'b01);
      ticks(5);
      check_now("over_hold", 3'd5, 0, 1, 4'd7, 4'd2, 2'b01);
      chk_val("serve_count9", serve_cnt, 9);
      start = 1'b1;
      step("restart", 0, 3'd1, 0, 1, 4'd0, 4'd0, 2'b00);
      start = 1'b0;

      // asynchronous reset between clock edges
      ticks(10);
      rst_n = 1'b0;
      #1;
      check_now("async_reset", 3'd0, 0, 1, 4'd0, 4'd0, 2'b00);
      chk_val("async_serve", int'(serve), 0);
      cyc(1'b0);
      rst_n = 1'b1;
      step("post_reset", 1, 3'd0, 0, 1, 4'd0, 4'd0, 2'b00);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
